// File: rtl/bram_pkg.sv
// Shared types for the simple-dual-port block RAM: FSM states and
// read-during-write mode encodings.
package bram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/bram_sdp_core.sv
// Storage array with byte-enable write port and a registered read port.
// Out-of-range addresses (non power-of-2 DEPTH) never touch the array;
// reading one returns zero.
module bram_sdp_core #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB     = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = {1'b0, wr_addr} < DEPTH_L;
  assign rd_ok = {1'b0, rd_addr} < DEPTH_L;

  // Byte-lane write: only lanes with their enable set are updated.
  // NOTE: the array itself has no reset; the clear sweep in the parent zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read; holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
  end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM with a post-reset clear sweep, selectable
// read-during-write behaviour and one or two cycles of read latency.
module bram_sdp
  import bram_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int RD_LAT   = 1,
  parameter  int RDW_MODE = 0,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int NB       = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = DEPTH[ADDR_W:0];

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              busy_q;
  logic              rd_acc;
  logic              wr_acc;
  logic              same_addr;

  logic              c_wr_en;
  logic [ADDR_W-1:0] c_wr_addr;
  logic [WIDTH-1:0]  c_wr_data;
  logic [NB-1:0]     c_wr_be;
  logic [WIDTH-1:0]  core_q;

  logic              v1;
  logic [NB-1:0]     byp_be;
  logic [WIDTH-1:0]  byp_data;
  logic [WIDTH-1:0]  d1;
  logic              valid_q;
  logic [WIDTH-1:0]  data_q;

  assign rd_acc    = rd_en && (state == READY) && !rst;
  assign wr_acc    = wr_en && (state == READY) && !rst;
  assign same_addr = (wr_addr == rd_addr) && ({1'b0, rd_addr} < DEPTH_L);

  // Clear FSM: sweep zeros through every address, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == LAST_ADDR) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Write port mux: the sweep owns the write port while clearing.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    c_wr_en   = wr_acc;
    c_wr_addr = wr_addr;
    c_wr_data = wr_data;
    c_wr_be   = wr_be;
    if (state == CLEAR) begin
      c_wr_en   = !rst;
      c_wr_addr = clr_cnt;
      c_wr_data = '0;
      c_wr_be   = '1;
    end
  end

  bram_sdp_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (c_wr_en),
    .wr_addr (c_wr_addr),
    .wr_data (c_wr_data),
    .wr_be   (c_wr_be),
    .rd_en   (rd_acc),
    .rd_addr (rd_addr),
    .rd_data (core_q)
  );

  // First read stage: valid flag plus the write bytes to forward on a same-address collision.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      byp_be   <= '0;
      byp_data <= '0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) begin
        byp_data <= wr_data;
        byp_be   <= (RDW_MODE == RDW_NEW && wr_acc && same_addr) ? wr_be : '0;
      end
    end
  end

  // Merge forwarded bytes over the array's old data.
  always_comb begin
    d1 = core_q;
    for (int b = 0; b < NB; b++) begin
      if (byp_be[b]) d1[b*8 +: 8] = byp_data[b*8 +: 8];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      // Plain output register stage; no stall path.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= v1;
          if (v1) data_q <= d1;
        end
      end
    end else begin : g_lat1
      assign valid_q = v1;
      assign data_q  = d1;
    end
  endgenerate

  // Reset forces the idle/busy output values for the whole time it is held.
  assign rd_valid = valid_q && !rst;
  assign rd_data  = rst ? '0 : data_q;
  assign busy     = busy_q || rst;

endmodule
